mem_responder: RTL

- Responder (target) end of the MemoryBus write/read signal set. Accepts initiator writes and reads and serves them from an internal word-addressed RAM.
- Sits between the core load/store path (or instruction fetch) and on-chip data memory.
- Read data returns after a fixed, parameterised latency, with a valid strobe and per-access address-error flags.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_rd_pipe.sv | 39 +++
 rtl/mem_responder.sv | 93 +++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and address decode for the mem_responder slice.
package mem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    logic  err;
    word_t data;
  } rd_resp_t;

  // Subtraction wraps modulo 2^32, so addresses below base land far out of range.
  function automatic logic in_range(addr_t addr, addr_t base, int unsigned depth);
    addr_t off;
    off = addr - base;
    return (off < (depth << 2)) && (addr[1:0] == 2'b00);
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: MemoryBus write/read signal set between initiator and responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic  wr_en;
  addr_t wr_addr;
  word_t wr_data;
  logic  rd_en;
  addr_t rd_addr;
  word_t rd_data;
  logic  rd_valid;
  logic  rd_err;
  logic  wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_err, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, rd_err, wr_err
  );
endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: STAGES-deep shift register of read responses, async active-low clear.
// Data only advances alongside a valid, so the last stage holds the most recent response.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rd_resp_t head,
  output rd_resp_t tail
);

  rd_resp_t stage [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= head.valid;
      stage[0].err   <= head.valid & head.err;
      if (head.valid) begin
        stage[0].data <= head.data;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        stage[i].valid <= stage[i-1].valid;
        stage[i].err   <= stage[i-1].err;
        if (stage[i-1].valid) begin
          stage[i].data <= stage[i-1].data;
        end
      end
    end
  end

  assign tail = stage[STAGES-1];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word RAM target for MemoryBus; reads return after RD_LATENCY cycles, fully
// pipelined, no backpressure. Defining MEM_STATS_EN adds rd_count/wr_count access counters.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter addr_t       BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic clk,
  input  logic rst,
  mem_responder_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output word_t rd_count,
  output word_t wr_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  typedef logic [IDX_W-1:0] idx_t;

  word_t    mem [DEPTH_WORDS];
  logic     wr_ok;
  logic     rd_ok;
  idx_t     wr_idx;
  idx_t     rd_idx;
  rd_resp_t head;
  rd_resp_t tail;

  assign wr_ok  = in_range(bus.wr_addr, BASE_ADDR, DEPTH_WORDS);
  assign rd_ok  = in_range(bus.rd_addr, BASE_ADDR, DEPTH_WORDS);
  assign wr_idx = idx_t'((bus.wr_addr - BASE_ADDR) >> 2);
  assign rd_idx = idx_t'((bus.rd_addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_ok) begin
      mem[wr_idx] <= bus.wr_data;
    end
  end

  // Write-first: a same-cycle write to the read word bypasses the array.
  always_comb begin
    head       = '0;
    head.valid = bus.rd_en;
    head.err   = !rd_ok;
    if (rd_ok) begin
      if (bus.wr_en && wr_ok && (wr_idx == rd_idx)) begin
        head.data = bus.wr_data;
      end else begin
        head.data = mem[rd_idx];
      end
    end
  end

  mem_rd_pipe #(
    .STAGES(RD_LATENCY)
  ) u_rd_pipe (
    .clk (clk),
    .rst (rst),
    .head(head),
    .tail(tail)
  );

  assign bus.rd_data  = tail.data;
  assign bus.rd_valid = tail.valid;
  assign bus.rd_err   = tail.err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wr_err <= 1'b0;
    end else begin
      bus.wr_err <= bus.wr_en && !wr_ok;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (bus.rd_en) begin
        rd_count <= rd_count + 32'd1;
      end
      if (bus.wr_en) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end
`endif

endmodule
